// File: rtl/register_bank_sp.sv
// General-purpose register file with a hardware stack pointer and a link register.
// It has two combinational read ports, one write port, optional write-to-read bypass and a sticky stack fault flag.
module register_bank_sp #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 5,
    parameter int                RA_IDX     = 1,
    parameter int                SP_IDX     = 2,
    parameter int                WORD_BYTES = 4,
    parameter logic [DATA_W-1:0] SP_RESET   = 'h0000_0FFC,
    parameter logic [DATA_W-1:0] SP_LIMIT   = 'h0000_0800,
    parameter bit                BYPASS     = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              reg_write,
    input  logic              nop,
    input  logic              jal,
    input  logic [DATA_W-1:0] link_data,
    input  logic              stack_op,
    input  logic              stack_push,
    input  logic              fault_clr,
    output logic [DATA_W-1:0] dado1,
    output logic [DATA_W-1:0] dado2,
    output logic [DATA_W-1:0] stack_addr,
    output logic [DATA_W-1:0] sp_out,
    output logic              stack_fault
);
    localparam int                NREGS = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] STEP  = DATA_W'(WORD_BYTES);

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] nval [NREGS];
    logic [NREGS-1:0]  hit;
    logic [DATA_W-1:0] sp, sp_next, r1, r2;
    logic [DATA_W:0]   sp_dec, sp_inc;
    logic              push_ok, pop_ok, sp_accept, sp_reject;

    assign sp = regs[SP_IDX];

    // One extra bit catches wrap-around in either direction.
    assign sp_dec    = {1'b0, sp} - {1'b0, STEP};
    assign sp_inc    = {1'b0, sp} + {1'b0, STEP};
    assign push_ok   = !sp_dec[DATA_W] && (sp_dec[DATA_W-1:0] >= SP_LIMIT);
    assign pop_ok    = sp_inc <= {1'b0, SP_RESET};
    assign sp_accept = stack_op && (stack_push ? push_ok : pop_ok);
    assign sp_reject = stack_op && !sp_accept;
    assign sp_next   = stack_push ? sp_dec[DATA_W-1:0] : sp_inc[DATA_W-1:0];

    assign stack_addr = !stack_op ? '0 : (stack_push ? sp_dec[DATA_W-1:0] : sp);
    assign sp_out     = regs[SP_IDX];

    // Per-register commit value. Later assignments take priority: SP step > link > reg_write.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            hit[i]  = 1'b0;
            nval[i] = regs[i];
            if (reg_write && rd == ADDR_W'(i)) begin
                hit[i]  = 1'b1;
                nval[i] = wr_data;
            end
            if (jal && i == RA_IDX) begin
                hit[i]  = 1'b1;
                nval[i] = link_data;
            end
            if (sp_accept && i == SP_IDX) begin
                hit[i]  = 1'b1;
                nval[i] = sp_next;
            end
            if (i == 0) hit[i] = 1'b0;
        end
    end

    always_comb begin
        r1    = (BYPASS && hit[rs]) ? nval[rs] : regs[rs];
        r2    = (BYPASS && hit[rt]) ? nval[rt] : regs[rt];
        dado1 = nop ? '0 : r1;
        dado2 = nop ? '0 : r2;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
            stack_fault <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++)
                if (hit[i]) regs[i] <= nval[i];
            if (sp_reject)      stack_fault <= 1'b1;
            else if (fault_clr) stack_fault <= 1'b0;
        end
    end
endmodule

// File: tb/tb_register_bank_sp.sv
// Bench for register_bank_sp: an array-based reference model is compared against the DUT every cycle.
// Literal checks on the directed scenarios pin the model itself.
module tb_register_bank_sp;
    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  rs, rt, rd;
    logic [31:0] wr_data, link_data;
    logic        reg_write, nop, jal, stack_op, stack_push, fault_clr;
    logic [31:0] dado1, dado2, stack_addr, sp_out;
    logic        stack_fault;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    logic [31:0] mregs [32];
    logic        mfault;

    register_bank_sp dut (
        .clock(clock), .reset(reset), .rs(rs), .rt(rt), .rd(rd), .wr_data(wr_data),
        .reg_write(reg_write), .nop(nop), .jal(jal), .link_data(link_data),
        .stack_op(stack_op), .stack_push(stack_push), .fault_clr(fault_clr),
        .dado1(dado1), .dado2(dado2), .stack_addr(stack_addr), .sp_out(sp_out),
        .stack_fault(stack_fault)
    );

    initial forever #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stack rule from bounds: push needs SP-4 >= 0x800, pop needs SP+4 <= 0xFFC.
    function automatic bit m_ok();
        longint sp = longint'(mregs[2]);
        return stack_push ? (sp - 4 >= 64'h800) : (sp + 4 <= 64'hFFC);
    endfunction

    function automatic logic [31:0] m_newsp();
        return stack_push ? mregs[2] - 32'd4 : mregs[2] + 32'd4;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0)                             return 32'h0;
        if (stack_op && m_ok() && a == 5'd2)    return m_newsp();
        if (jal && a == 5'd1)                   return link_data;
        if (reg_write && rd == a)               return wr_data;
        return mregs[a];
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            foreach (mregs[i]) mregs[i] = 32'h0;
            mregs[2] = 32'h0FFC;
            mfault   = 1'b0;
        end else begin
            bit          ok;
            logic [31:0] nsp;
            ok  = m_ok();
            nsp = m_newsp();
            if (reg_write && rd != 0) mregs[rd] = wr_data;
            if (jal)                  mregs[1]  = link_data;
            if (stack_op && ok)       mregs[2]  = nsp;
            if (stack_op && !ok)      mfault    = 1'b1;
            else if (fault_clr)       mfault    = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("dado1", dado1, nop ? 32'h0 : m_read(rs));
            chk("dado2", dado2, nop ? 32'h0 : m_read(rt));
            chk("stack_addr", stack_addr,
                !stack_op ? 32'h0 : (stack_push ? mregs[2] - 32'd4 : mregs[2]));
            chk("sp_out", sp_out, mregs[2]);
            chk("stack_fault", {31'h0, stack_fault}, {31'h0, mfault});
        end
    end

    task automatic clr();
        rs = 0; rt = 0; rd = 0; wr_data = 0; link_data = 0;
        reg_write = 0; nop = 0; jal = 0; stack_op = 0; stack_push = 0; fault_clr = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        clr();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk_en = 1'b1;

        // Reset state
        chk("rst_sp_out", sp_out, 32'h0FFC);
        chk("rst_fault", {31'h0, stack_fault}, 32'h0);
        rs = 2; #1 chk("rst_r2", dado1, 32'h0FFC);
        for (int i = 0; i < 32; i++) begin
            rs = 5'(i); rt = 5'(31 - i);
            tick();
        end
        clr();

        // Bypass and R0
        reg_write = 1; rd = 5; wr_data = 32'hDEADBEEF; rs = 5;
        #1 chk("bypass_r5", dado1, 32'hDEADBEEF);
        tick();
        rd = 0; wr_data = 32'h1234; rs = 0; rt = 5;
        #1 chk("r0_bypass", dado1, 32'h0);
        chk("r5_held", dado2, 32'hDEADBEEF);
        tick(); clr();
        rs = 0; #1 chk("r0_zero", dado1, 32'h0);
        tick();

        // Push, push, pop
        stack_op = 1; stack_push = 1;
        #1 chk("push1_addr", stack_addr, 32'h0FF8);
        tick();
        chk("push2_addr", stack_addr, 32'h0FF4);
        tick();
        chk("push_sp", sp_out, 32'h0FF4);
        stack_push = 0;
        #1 chk("pop_addr", stack_addr, 32'h0FF4);
        tick();
        chk("pop_sp", sp_out, 32'h0FF8);

        // Bounds
        tick();
        chk("top_sp", sp_out, 32'h0FFC);
        tick();
        chk("underflow_sp", sp_out, 32'h0FFC);
        chk("underflow_fault", {31'h0, stack_fault}, 32'h1);
        clr(); fault_clr = 1;
        tick();
        chk("fault_clr", {31'h0, stack_fault}, 32'h0);
        clr(); reg_write = 1; rd = 2; wr_data = 32'h0804;
        tick();
        chk("sp_wr", sp_out, 32'h0804);
        clr(); stack_op = 1; stack_push = 1;
        tick();
        chk("lim_push_sp", sp_out, 32'h0800);
        chk("lim_push_fault", {31'h0, stack_fault}, 32'h0);
        tick();
        chk("overflow_sp", sp_out, 32'h0800);
        chk("overflow_fault", {31'h0, stack_fault}, 32'h1);
        fault_clr = 1;
        tick();
        chk("clr_vs_fault", {31'h0, stack_fault}, 32'h1);
        clr(); fault_clr = 1;
        tick();

        // jal vs reg_write, SP step vs reg_write
        clr(); jal = 1; link_data = 32'h40; reg_write = 1; rd = 1; wr_data = 32'h99; rs = 1;
        #1 chk("jal_bypass", dado1, 32'h40);
        tick();
        clr(); rs = 1;
        #1 chk("jal_r1", dado1, 32'h40);
        reg_write = 1; rd = 2; wr_data = 32'h0FFC;
        tick();
        clr(); jal = 1; link_data = 32'h80; reg_write = 1; rd = 9; wr_data = 32'h9;
        tick();
        clr(); rs = 9; rt = 1;
        #1 chk("parallel_r9", dado1, 32'h9);
        chk("parallel_r1", dado2, 32'h80);
        stack_op = 1; stack_push = 1; reg_write = 1; rd = 2; wr_data = 32'h555; rs = 2;
        #1 chk("sp_prio_bypass", dado1, 32'h0FF8);
        tick();
        chk("sp_prio", sp_out, 32'h0FF8);

        // nop
        clr(); nop = 1; rs = 5; rt = 2; reg_write = 1; rd = 7; wr_data = 32'h77;
        #1 chk("nop_d1", dado1, 32'h0);
        chk("nop_d2", dado2, 32'h0);
        tick();
        clr(); rs = 7;
        #1 chk("nop_commit", dado1, 32'h77);
        tick();

        // Mixed traffic against the model
        for (int i = 0; i < 60; i++) begin
            rs = 5'($urandom_range(0, 31)); rt = 5'($urandom_range(0, 31));
            rd = 5'($urandom_range(0, 31)); wr_data = $urandom;
            link_data = $urandom;
            reg_write = 1'($urandom_range(0, 1)); jal = ($urandom_range(0, 4) == 0);
            nop = ($urandom_range(0, 5) == 0); stack_op = 1'($urandom_range(0, 1));
            stack_push = 1'($urandom_range(0, 1)); fault_clr = ($urandom_range(0, 3) == 0);
            tick();
        end
        clr();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
